mmu_table_load_multi: RTL and testbench
=======================================

MMU_TABLE_LOAD_MULTI -- requirements
Module: mmu_table_load_multi

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  P_DEPTH     4   maximum outstanding memory loads; power of two, at least 2
  P_DEPTH_N   2   log2(P_DEPTH)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  iCLOCK          in   1            sole clock; all state updates on rising edge
  iRESET_SYNC     in   1            synchronous reset, active-high
  iLD_REQ         in   1            load request from walker
  iLD_ADDR        in   32           physical table-entry address
  oLD_BUSY        out  1            request not accepted this cycle
  oMEM_REQ        out  1            memory request
  iMEM_LOCK       in   1            memory pipe stalled; request not taken
  oMEM_ADDR       out  32           memory request address
  iMEM_VALID      in   1            in-order memory response
  iMEM_DATA       in   64           response data (8-byte line)
  oDONE_VALID     out  1            load complete, 1-cycle pulse
  oDONE_DATA      out  32           selected table entry
  oDONE_ADDR      out  32           address of the completed load
  oDONE_FLAG0     out  12           iMEM_DATA[11:0] of response
  oDONE_FLAG1     out  12           iMEM_DATA[43:32] of response
  oPENDING        out  P_DEPTH_N+1  issued, unanswered loads
  oERR_UNDERFLOW  out  1            sticky: response with no pending load
REQ-003 Clock and reset SHALL be exactly one clock, iCLOCK, and a synchronous, active-high reset, iRESET_SYNC.

Function
REQ-004 The block SHALL assert oLD_BUSY whenever the hold register is valid or oPENDING == P_DEPTH.
REQ-005 A request SHALL be accepted in the cycle iLD_REQ=1 and oLD_BUSY=0.
REQ-006 With the hold register empty, oMEM_REQ SHALL equal iLD_REQ && !oLD_BUSY and oMEM_ADDR SHALL equal iLD_ADDR, combinationally, for zero-cycle issue.
REQ-007 With the hold register valid, oMEM_REQ SHALL be 1 and oMEM_ADDR SHALL be the held address.
REQ-008 A request SHALL be issued in any cycle with oMEM_REQ=1 and iMEM_LOCK=0.
REQ-009 On issue, the address SHALL be pushed into the pending FIFO and the hold register cleared.
REQ-010 An accepted request with iMEM_LOCK=1 SHALL load the hold register and be retried every cycle until issued.
REQ-011 Hold-register state machine: EMPTY -> HELD on accept with lock; HELD -> EMPTY on issue; no other transitions.
REQ-012 Responses SHALL be in order: each iMEM_VALID pops the FIFO head.
REQ-013 A pop SHALL produce, registered one cycle later:
  - oDONE_VALID=1
  - oDONE_ADDR = head address
  - oDONE_DATA = iMEM_DATA[63:32] when head[2]=1, else iMEM_DATA[31:0]
  - oDONE_FLAG0 and oDONE_FLAG1 per REQ-002
REQ-014 oDONE_* data outputs SHALL hold their last value while oDONE_VALID=0.
REQ-015 oPENDING SHALL change by +1 on issue only, -1 on pop only, and 0 when both occur in the same cycle.
REQ-016 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full.
REQ-017 iMEM_VALID while oPENDING == 0 SHALL be dropped and SHALL set oERR_UNDERFLOW, even if an issue occurs in the same cycle; no oDONE_VALID is produced.
REQ-018 Pointers SHALL wrap modulo P_DEPTH.
REQ-019 oPENDING SHALL never exceed P_DEPTH.

Reset
REQ-020 In a reset cycle, the block SHALL:
  - empty the FIFO and hold register
  - set oPENDING to 0
  - clear oERR_UNDERFLOW
  - drive oDONE_VALID=0 and all oDONE_* data to 0
  - ignore iLD_REQ and iMEM_VALID
REQ-021 During reset, oMEM_REQ SHALL be 0.
REQ-022 Reset mid-operation SHALL discard all pending loads.
REQ-023 Responses to discarded loads arriving after reset SHALL be treated per REQ-017; the system quiesces memory before reset.

Structure
REQ-024 Package mmu_pkg SHALL hold:
  - flag field bit ranges (11:0, 43:32)
  - the word-select address bit (2)
  - the 12-bit flag width
REQ-025 The pending-address FIFO SHALL be the sub-module mmu_table_load_fifo (synchronous, parametrised depth and width, count output).

Verification
REQ-026 Single load: iLD_ADDR=0x1004, no lock; iMEM_VALID with data 0xAAAA0BBB_CCCC0DDD two cycles later -> one cycle after the response, oDONE_DATA=0xAAAA0BBB, oDONE_FLAG0=0xDDD, oDONE_FLAG1=0xBBB, oDONE_ADDR=0x1004.
REQ-027 Lock: iMEM_LOCK=1 for 3 cycles on accept -> oMEM_REQ high 4 cycles at the same address, oLD_BUSY high 3 cycles, oPENDING=1 after release.
REQ-028 Full: 4 back-to-back requests with no responses -> oPENDING=4, oLD_BUSY=1; a 5th is accepted only in the cycle after the first response.
REQ-029 Simultaneous push/pop at oPENDING=4 -> oPENDING stays 4; completions return in issue order with wrap verified over 10 loads.
REQ-030 Stray iMEM_VALID at oPENDING=0 -> no oDONE_VALID, oERR_UNDERFLOW=1 until iRESET_SYNC.
REQ-031 iRESET_SYNC with 3 loads pending -> oPENDING=0 and oMEM_REQ=0 next cycle; a fresh load then completes normally.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared constants and types for the page-table load unit.
// Flag field positions and word-select bit within an 8-byte memory line.
package mmu_pkg;
    localparam int FLAG_W    = 12;
    localparam int FLAG0_LSB = 0;
    localparam int FLAG0_MSB = 11;
    localparam int FLAG1_LSB = 32;
    localparam int FLAG1_MSB = 43;
    localparam int WSEL_BIT  = 2;

    typedef enum logic {
        HOLD_EMPTY,
        HOLD_HELD
    } hold_state_t;

    // Pick the 32-bit table entry out of the 8-byte line using the address word bit.
    function automatic logic [31:0] sel_entry(input logic [31:0] addr, input logic [63:0] line);
        return addr[WSEL_BIT] ? line[63:32] : line[31:0];
    endfunction
endpackage

// File: rtl/mmu_table_load_fifo.sv
// Synchronous pending-address FIFO with combinational head and occupancy count.
// Push and pop may coincide, including when full; caller never pushes a full FIFO without popping.
module mmu_table_load_fifo #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2,
    parameter int WIDTH   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   push_dat_i,
    input  logic               pop_i,
    output logic [WIDTH-1:0]   head_dat_o,
    output logic [DEPTH_N:0]   count_o
);
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH_N-1:0] wptr_q;
    logic [DEPTH_N-1:0] rptr_q;
    logic [DEPTH_N:0]   count_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_dat_o = mem_q[rptr_q];
    assign count_o    = count_q;
endmodule

// File: rtl/mmu_table_load_multi.sv
// Multi-outstanding page-table entry loader: zero-cycle issue, one hold slot for a locked
// memory pipe, in-order responses retired one cycle after arrival through a pending FIFO.
module mmu_table_load_multi
    import mmu_pkg::*;
#(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    input  logic                 iLD_REQ,
    input  logic [31:0]          iLD_ADDR,
    output logic                 oLD_BUSY,
    output logic                 oMEM_REQ,
    input  logic                 iMEM_LOCK,
    output logic [31:0]          oMEM_ADDR,
    input  logic                 iMEM_VALID,
    input  logic [63:0]          iMEM_DATA,
    output logic                 oDONE_VALID,
    output logic [31:0]          oDONE_DATA,
    output logic [31:0]          oDONE_ADDR,
    output logic [FLAG_W-1:0]    oDONE_FLAG0,
    output logic [FLAG_W-1:0]    oDONE_FLAG1,
    output logic [P_DEPTH_N:0]   oPENDING,
    output logic                 oERR_UNDERFLOW
);
    hold_state_t          hold_q;
    logic [31:0]          hold_addr_q;
    logic [P_DEPTH_N:0]   pend_cnt;
    logic [31:0]          head_addr;
    logic                 held, accept, issue, pop, stray;

    logic                 done_vld_q;
    logic [31:0]          done_data_q, done_addr_q;
    logic [FLAG_W-1:0]    done_f0_q, done_f1_q;
    logic                 err_q, err_d;

    assign held     = (hold_q == HOLD_HELD);
    assign oLD_BUSY = held || (pend_cnt == P_DEPTH[P_DEPTH_N:0]);
    assign accept   = !iRESET_SYNC && iLD_REQ && !oLD_BUSY;
    assign oMEM_REQ = !iRESET_SYNC && (held || accept);
    assign oMEM_ADDR = held ? hold_addr_q : iLD_ADDR;
    assign issue    = oMEM_REQ && !iMEM_LOCK;
    // Occupancy before this cycle's push decides drop vs pop, so a same-cycle issue cannot absorb a stray.
    assign pop      = !iRESET_SYNC && iMEM_VALID && (pend_cnt != '0);
    assign stray    = !iRESET_SYNC && iMEM_VALID && (pend_cnt == '0);
    assign err_d    = err_q || stray;

    mmu_table_load_fifo #(
        .DEPTH   (P_DEPTH),
        .DEPTH_N (P_DEPTH_N),
        .WIDTH   (32)
    ) u_fifo (
        .clk_i      (iCLOCK),
        .rst_i      (iRESET_SYNC),
        .push_i     (issue),
        .push_dat_i (oMEM_ADDR),
        .pop_i      (pop),
        .head_dat_o (head_addr),
        .count_o    (pend_cnt)
    );

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            hold_q      <= HOLD_EMPTY;
            hold_addr_q <= '0;
        end else begin
            case (hold_q)
                HOLD_EMPTY: if (accept && iMEM_LOCK) begin
                    hold_q      <= HOLD_HELD;
                    hold_addr_q <= iLD_ADDR;
                end
                HOLD_HELD: if (!iMEM_LOCK) hold_q <= HOLD_EMPTY;
            endcase
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            done_vld_q  <= 1'b0;
            done_data_q <= '0;
            done_addr_q <= '0;
            done_f0_q   <= '0;
            done_f1_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            done_vld_q <= pop;
            err_q      <= err_d;
            if (pop) begin
                done_addr_q <= head_addr;
                done_data_q <= sel_entry(head_addr, iMEM_DATA);
                done_f0_q   <= iMEM_DATA[FLAG0_MSB:FLAG0_LSB];
                done_f1_q   <= iMEM_DATA[FLAG1_MSB:FLAG1_LSB];
            end
        end
    end

    assign oDONE_VALID    = done_vld_q;
    assign oDONE_DATA     = done_data_q;
    assign oDONE_ADDR     = done_addr_q;
    assign oDONE_FLAG0    = done_f0_q;
    assign oDONE_FLAG1    = done_f1_q;
    assign oPENDING       = pend_cnt;
    assign oERR_UNDERFLOW = err_q;
endmodule

// File: tb/tb_mmu_table_load_multi.sv
// Bench for mmu_table_load_multi: queue-based reference model drives directed and random
// traffic; completions are checked by an independent monitor against a scoreboard queue.
module tb_mmu_table_load_multi;
    localparam int DEPTH = 4;

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC = 1'b1;
    logic        iLD_REQ = 1'b0;
    logic [31:0] iLD_ADDR = '0;
    logic        oLD_BUSY, oMEM_REQ;
    logic        iMEM_LOCK = 1'b0;
    logic [31:0] oMEM_ADDR;
    logic        iMEM_VALID = 1'b0;
    logic [63:0] iMEM_DATA = '0;
    logic        oDONE_VALID;
    logic [31:0] oDONE_DATA, oDONE_ADDR;
    logic [11:0] oDONE_FLAG0, oDONE_FLAG1;
    logic [2:0]  oPENDING;
    logic        oERR_UNDERFLOW;

    mmu_table_load_multi #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
        .iLD_REQ(iLD_REQ), .iLD_ADDR(iLD_ADDR), .oLD_BUSY(oLD_BUSY),
        .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(iMEM_LOCK), .oMEM_ADDR(oMEM_ADDR),
        .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA),
        .oDONE_VALID(oDONE_VALID), .oDONE_DATA(oDONE_DATA), .oDONE_ADDR(oDONE_ADDR),
        .oDONE_FLAG0(oDONE_FLAG0), .oDONE_FLAG1(oDONE_FLAG1),
        .oPENDING(oPENDING), .oERR_UNDERFLOW(oERR_UNDERFLOW)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [11:0] f0;
        logic [11:0] f1;
    } done_t;

    done_t       exp_q[$];
    logic [31:0] pend[$];
    logic        m_held = 1'b0;
    logic [31:0] m_haddr = '0;
    logic        m_err = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          n_done = 0;
    done_t       last_done = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare the combinational/registered view at negedge.
    task automatic cyc(input logic req, input logic [31:0] addr, input logic lock,
                       input logic vld, input logic [63:0] data, input logic rst);
        int    size0;
        logic  err0, busy_e, acc, mreq_e, issue;
        logic [31:0] maddr_e, head;
        done_t d;
        @(posedge iCLOCK);
        #1;
        iLD_REQ = req; iLD_ADDR = addr; iMEM_LOCK = lock;
        iMEM_VALID = vld; iMEM_DATA = data; iRESET_SYNC = rst;
        size0   = pend.size();
        err0    = m_err;
        busy_e  = m_held || (size0 == DEPTH);
        acc     = !rst && req && !busy_e;
        mreq_e  = !rst && (m_held || acc);
        maddr_e = m_held ? m_haddr : addr;
        issue   = mreq_e && !lock;
        if (rst) begin
            pend.delete();
            m_held = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (vld && size0 > 0) begin
                head   = pend.pop_front();
                d.addr = head;
                d.data = head[2] ? data[63:32] : data[31:0];
                d.f0   = data[11:0];
                d.f1   = data[43:32];
                exp_q.push_back(d);
            end else if (vld) begin
                m_err = 1'b1;
            end
            if (issue) begin
                pend.push_back(maddr_e);
                m_held = 1'b0;
            end else if (acc) begin
                m_held  = 1'b1;
                m_haddr = addr;
            end
        end
        @(negedge iCLOCK);
        chk("busy", oLD_BUSY, busy_e);
        chk("mem_req", oMEM_REQ, mreq_e);
        if (mreq_e) chk("mem_addr", oMEM_ADDR, maddr_e);
        chk("pending", oPENDING, size0);
        chk("err", oERR_UNDERFLOW, err0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_addr();
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [63:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // Monitor: independent of the driver, pops the scoreboard on every completion.
    initial begin : monitor
        logic  prev_rst;
        done_t hold_v, e;
        prev_rst = 1'b1;
        hold_v   = '0;
        forever begin
            @(negedge iCLOCK);
            if (prev_rst) begin
                hold_v = '0;
                chk("rst_done_vld", oDONE_VALID, 1'b0);
            end
            if (oDONE_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_addr", oDONE_ADDR, e.addr);
                    chk("done_data", oDONE_DATA, e.data);
                    chk("done_f0", oDONE_FLAG0, e.f0);
                    chk("done_f1", oDONE_FLAG1, e.f1);
                    hold_v = e;
                    last_done = e;
                    n_done++;
                end
            end else begin
                chk("hold_addr", oDONE_ADDR, hold_v.addr);
                chk("hold_data", oDONE_DATA, hold_v.data);
                chk("hold_flags", {oDONE_FLAG0, oDONE_FLAG1}, {hold_v.f0, hold_v.f1});
            end
            prev_rst = iRESET_SYNC;
        end
    end

    initial begin : driver
        int guard;
        cyc(1'b1, 32'h40, 1'b0, 1'b1, 64'h1, 1'b1);
        idle(2);

        // single load with word-select high
        cyc(1'b1, 32'h1004, 1'b0, 1'b0, 64'h0, 1'b0);
        idle(1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 64'hAAAA0BBB_CCCC0DDD, 1'b0);
        idle(2);
        chk("single_data", last_done.data, 32'hAAAA0BBB);
        chk("single_f0", last_done.f0, 12'hDDD);
        chk("single_f1", last_done.f1, 12'hBBB);
        chk("single_addr", last_done.addr, 32'h1004);

        // lock for three cycles at accept
        cyc(1'b1, 32'h2000, 1'b1, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 32'h3000, 1'b1, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 32'h3000, 1'b1, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        idle(1);
        chk("lock_pending", oPENDING, 3'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, rnd_data(), 1'b0);
        idle(2);

        // fill to depth, then sustained push/pop to wrap the pointers
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0, 64'h0, 1'b0);
        chk("full_pending", oPENDING, 3'd4);
        chk("full_busy", oLD_BUSY, 1'b1);
        for (int i = 0; i < 14; i++) cyc(1'b1, 32'h800 + 32'(i * 4), 1'b0, 1'b1, rnd_data(), 1'b0);
        guard = 0;
        while (pend.size() > 0 && guard < 20) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1, rnd_data(), 1'b0);
            guard++;
        end
        idle(2);

        // stray response with a same-cycle issue
        cyc(1'b1, 32'h5000, 1'b0, 1'b1, rnd_data(), 1'b0);
        idle(3);
        chk("stray_err", oERR_UNDERFLOW, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, rnd_data(), 1'b0);

        // reset with three loads outstanding, then a fresh load
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h6000 + 32'(i * 8), 1'b0, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 32'h7000, 1'b0, 1'b1, rnd_data(), 1'b1);
        idle(1);
        chk("post_rst_pending", oPENDING, 3'd0);
        chk("post_rst_err", oERR_UNDERFLOW, 1'b0);
        cyc(1'b1, 32'h9008, 1'b0, 1'b0, 64'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 64'h11112222_33334444, 1'b0);
        idle(2);
        chk("fresh_data", last_done.data, 32'h33334444);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic v;
            v = (pend.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 2);
            cyc($urandom_range(0, 9) < 6, rnd_addr(), $urandom_range(0, 9) < 3,
                v, rnd_data(), $urandom_range(0, 199) == 0);
        end
        guard = 0;
        while ((pend.size() > 0 || m_held) && guard < 40) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1, rnd_data(), 1'b0);
            guard++;
        end
        idle(3);
        chk("drain_model", pend.size(), 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("some_done", n_done > 50, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
